pwm_multi: RTL
==============

# pwm_multi

Multi-channel, parametrised PWM generator that succeeds the single-channel PWM peripheral. One shared period counter drives NUM_CH compare channels. Duty and period changes are double-buffered so they take effect only on a period boundary. Disable completes the current period gracefully. Sits behind the AXI register slave of the PWM IP; all control inputs come from that register file in the same clock domain.

## Interface
- NUM_CH, 4, number of PWM channels (1..32)
- CNT_W, 32, counter / period / duty width in bits (2..32)
- clk  input  1  system clock, all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- enable  input  1  run request, synchronous level
- period  input  CNT_W  period in clk cycles (shadow value)
- duty  input  NUM_CH*CNT_W  per-channel high time; channel i at bits [i*CNT_W +: CNT_W] (shadow value)
- polarity  input  NUM_CH  1 = invert channel output (active-low PWM)
- center  input  1  center-aligned mode select; present only with PWM_CENTER_ALIGNED_EN
- out  output  NUM_CH  PWM outputs, registered
- period_tick  output  1  one-cycle pulse on every period boundary while running
- busy  output  1  high in RUN or DRAIN

## Operation
- Active registers period_q, duty_q[i] (and center_q) load from the inputs at the start of every period and on leaving IDLE. Inputs are not sampled at any other time.
- Edge-aligned counting: cnt runs 0..period_q-1, then wraps to 0.
- Raw compare: raw[i] = (cnt < duty_q[i]).
  - duty_q >= period_q gives 100 % high.
  - duty_q = 0 gives constant low.
- Output: out[i] = raw[i] XOR polarity[i], where polarity is sampled live. In IDLE, out[i] = polarity[i] (inactive level).
- period_q = 0 or 1 while running: cnt is held at 0 and every cycle is a boundary. Raw output is high only if duty_q >= 1.
- FSM states (in package enum):
  - IDLE: cnt = 0.
  - RUN.
  - DRAIN.
- FSM transitions:
  - IDLE to RUN when enable = 1. Shadows load and cnt = 0 in the same edge.
  - RUN to DRAIN when enable = 0.
  - DRAIN to RUN when enable = 1, with no break in output and no extra boundary.
  - DRAIN to IDLE at the next period boundary.
- period_tick asserts in the cycle where cnt is at its last value (wrap pending) in RUN or DRAIN, including the final DRAIN boundary.
- All arithmetic is unsigned CNT_W-bit. Comparisons never overflow because cnt is always < max(period_q, 1).

## Timing
- Reset values: cnt = 0, state = IDLE, period_q = 0, duty_q = 0, out = polarity (combinationally at reset), period_tick = 0, busy = 0.
- Latency: enable sampled high at edge N puts cnt = 0 after N. out reflects cnt = 0 after edge N+1. The output is always one cycle behind cnt.
- New duty written mid-period appears at the first output cycle of the next period, never mid-period (glitch-free).
- resetn asserted mid-period forces reset values immediately, with no graceful completion.

## Configuration
- PWM_CENTER_ALIGNED_EN defined:
  - The center port exists. center_q loads with the other shadows.
  - With center_q = 1, cnt counts up 0..period_q-1, then down period_q-1..0. The period is 2*period_q cycles and both endpoints appear twice.
  - The boundary and the shadow load are at the bottom, after the down-count reaches 0.
  - High time is 2*min(duty_q, period_q), centered.
- PWM_CENTER_ALIGNED_EN undefined: no center port, no direction register, edge-aligned only.

## Structure
- Package pwm_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN);
  - the direction enum (UP, DOWN);
  - localparam MAX_CH = 32.
- Sub-module pwm_compare holds one channel's duty_q register, comparator, polarity XOR and output register. It is instantiated NUM_CH times via generate.
- The top level holds the FSM, cnt, period_q and period_tick.

## Test plan
- NUM_CH = 2, CNT_W = 8, period = 10, duty = {3, 7}, enable held -> out[0] high 3 of 10 cycles, out[1] high 7 of 10 cycles; period_tick every 10 cycles.
- duty[0] changed 3 to 8 at cnt = 4 -> current period stays 3 high; next period 8 high; no runt pulse.
- enable dropped at cnt = 2 with period = 10 -> period completes, final period_tick, then IDLE; busy low one cycle after boundary. Re-enable at cnt = 6 -> continuous output, no restart.
- Edge values: duty = 0 -> constant low; duty = 12 with period = 10 -> constant high; period = 0 -> cnt stuck at 0, no X.
- polarity = 2'b01 in IDLE -> out = 2'b01. Reset asserted mid-pulse -> out = polarity immediately, busy = 0.
- With PWM_CENTER_ALIGNED_EN, center = 1, period = 5, duty = 2 -> 10-cycle period; out high 4 cycles centered on cnt = 0; period_tick once per 10 cycles.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and limits for the multi-channel PWM generator.
package pwm_pkg;

    localparam int MAX_CH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_state_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_compare.sv
// One PWM channel: double-buffered duty register, compare against the shared
// counter, registered raw level and live polarity inversion.
module pwm_compare #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [CNT_W-1:0] duty_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             polarity_i,
    output logic             out_o
);

    logic [CNT_W-1:0] duty_q;
    logic [CNT_W-1:0] duty_d;
    logic             raw_q;
    logic             raw_d;

    // The compare uses the duty of the period that is ending, so a load on the
    // boundary edge only affects the first output cycle of the next period.
    always_comb begin
        duty_d = duty_q;
        if (load_i) begin
            duty_d = duty_i;
        end
        raw_d = run_i && (cnt_i < duty_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            duty_q <= '0;
            raw_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            raw_q  <= raw_d;
        end
    end

    assign out_o = raw_q ^ polarity_i;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, run/drain FSM, shadowed period.
// Optional center-aligned counting is enabled by defining PWM_CENTER_ALIGNED_EN.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic [NUM_CH-1:0]       polarity,
`ifdef PWM_CENTER_ALIGNED_EN
    input  logic                    center,
`endif
    output logic [NUM_CH-1:0]       out,
    output logic                    period_tick,
    output logic                    busy
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    if (NUM_CH < 1 || NUM_CH > MAX_CH || CNT_W < 2 || CNT_W > 32) begin : g_bad_param
        $error("pwm_multi: NUM_CH or CNT_W out of range");
    end

    pwm_state_e       state_q;
    pwm_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic [CNT_W-1:0] period_last;
    logic             short_per;
    logic             at_last;
    logic             running;
    logic             load;

`ifdef PWM_CENTER_ALIGNED_EN
    logic             center_q;
    logic             center_d;
    pwm_dir_e         dir_q;
    pwm_dir_e         dir_d;
`endif

    assign running     = (state_q != IDLE);
    assign short_per   = (period_q <= ONE);
    assign period_last = period_q - ONE;

    // Period 0 or 1 holds the counter at 0, so every running cycle is a boundary.
`ifdef PWM_CENTER_ALIGNED_EN
    assign at_last = short_per ||
                     (center_q ? (dir_q == DOWN && cnt_q == '0) : (cnt_q == period_last));
`else
    assign at_last = short_per || (cnt_q == period_last);
`endif

    assign period_tick = running && at_last;
    assign busy        = running;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        load     = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
        center_d = center_q;
        dir_d    = dir_q;
`endif

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (at_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (running) begin
            if (at_last) begin
                // A drain that ends here does not sample the inputs.
                cnt_d = '0;
                load  = (state_d != IDLE);
`ifdef PWM_CENTER_ALIGNED_EN
                dir_d = UP;
`endif
            end else begin
`ifdef PWM_CENTER_ALIGNED_EN
                if (center_q && dir_q == UP && cnt_q == period_last) begin
                    dir_d = DOWN;
                end else if (center_q && dir_q == DOWN) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
`else
                cnt_d = cnt_q + ONE;
`endif
            end
        end else if (state_d == RUN) begin
            cnt_d = '0;
            load  = 1'b1;
`ifdef PWM_CENTER_ALIGNED_EN
            dir_d = UP;
`endif
        end

        if (load) begin
            period_d = period;
`ifdef PWM_CENTER_ALIGNED_EN
            center_d = center;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

`ifdef PWM_CENTER_ALIGNED_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            center_q <= 1'b0;
            dir_q    <= UP;
        end else begin
            center_q <= center_d;
            dir_q    <= dir_d;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            pwm_compare #(
                .CNT_W(CNT_W)
            ) u_cmp (
                .clk        (clk),
                .resetn     (resetn),
                .load_i     (load),
                .run_i      (running),
                .duty_i     (duty[gi*CNT_W +: CNT_W]),
                .cnt_i      (cnt_q),
                .polarity_i (polarity[gi]),
                .out_o      (out[gi])
            );
        end
    endgenerate

endmodule
